// File: rtl/mem_port_arbiter.sv
// Two-requester memory port arbiter: data (D) has priority over instruction fetch (IF),
// with a starvation guard. One transaction in flight; IF responses can be cancelled by flush.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned MAX_STARVE = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_if_req_valid,
    output logic              o_if_req_ready,
    input  logic [ADDR_W-1:0] i_if_addr,
    input  logic              i_if_flush,
    output logic              o_if_rsp_valid,
    output logic [DATA_W-1:0] o_if_rsp_data,
    input  logic              i_d_req_valid,
    output logic              o_d_req_ready,
    input  logic              i_d_we,
    input  logic [ADDR_W-1:0] i_d_addr,
    input  logic [DATA_W-1:0] i_d_wdata,
    input  logic [2:0]        i_d_funct3,
    output logic              o_d_rsp_valid,
    output logic [DATA_W-1:0] o_d_rsp_data,
    output logic [ADDR_W-1:0] o_mem_read_address,
    output logic [2:0]        o_mem_funct3,
    output logic              o_mem_write_mem,
    output logic [ADDR_W-1:0] o_mem_write_address,
    output logic [DATA_W-1:0] o_mem_write_data,
    input  logic [DATA_W-1:0] i_mem_read_data
);
    localparam int unsigned SW      = $clog2(MAX_STARVE + 1);
    localparam logic [2:0]  F3_WORD = 3'b010;

    typedef enum logic [1:0] {StIdle, StWrite, StWait, StResp} state_e;

    state_e            r_state;
    state_e            w_state_d;
    logic [SW-1:0]     r_starve_cnt;
    logic              r_owner_if;
    logic              r_cancel;
    logic [ADDR_W-1:0] r_addr;
    logic [2:0]        r_funct3;
    logic [2:0]        r_wait_cnt;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rsp_data;

    logic w_if_elig;
    logic w_grant_if;
    logic w_grant_d;
    logic w_starved;

    // A grant is only ever issued to a valid requester, so grant == acceptance.
    always_comb begin
        w_if_elig  = i_if_req_valid & ~i_if_flush;
        w_starved  = (r_starve_cnt == SW'(MAX_STARVE));
        w_grant_if = 1'b0;
        w_grant_d  = 1'b0;
        if (r_state == StIdle) begin
            if (w_if_elig && w_starved) begin
                w_grant_if = 1'b1;
            end else if (i_d_req_valid) begin
                w_grant_d = 1'b1;
            end else if (w_if_elig) begin
                w_grant_if = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            StIdle: begin
                if (w_grant_d && i_d_we) begin
                    w_state_d = StWrite;
                end else if (w_grant_d || w_grant_if) begin
                    w_state_d = StWait;
                end
            end
            StWrite: w_state_d = StResp;
            StWait:  if (r_wait_cnt == 3'd1) w_state_d = StResp;
            StResp:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= StIdle;
            r_starve_cnt <= '0;
            r_owner_if   <= 1'b0;
            r_cancel     <= 1'b0;
            r_addr       <= '0;
            r_funct3     <= F3_WORD;
            r_wait_cnt   <= '0;
            r_wdata      <= '0;
            r_rsp_data   <= '0;
        end else begin
            r_state <= w_state_d;

            if (!i_if_req_valid || w_grant_if) begin
                r_starve_cnt <= '0;
            end else if (w_grant_d && !w_starved) begin
                r_starve_cnt <= r_starve_cnt + SW'(1);
            end

            if (w_grant_if || w_grant_d) begin
                r_owner_if <= w_grant_if;
                r_addr     <= w_grant_if ? i_if_addr : i_d_addr;
                r_funct3   <= w_grant_if ? F3_WORD : i_d_funct3;
                r_wait_cnt <= 3'(MEM_LAT);
                if (w_grant_d) begin
                    r_wdata <= i_d_wdata;
                end
            end

            if (r_state == StWrite) begin
                r_rsp_data <= '0;
            end else if (r_state == StWait) begin
                r_wait_cnt <= r_wait_cnt - 3'd1;
                if (r_wait_cnt == 3'd1) begin
                    r_rsp_data <= i_mem_read_data;
                end
            end

            if (r_state == StResp) begin
                r_cancel <= 1'b0;
            end else if (r_state == StWait && r_owner_if && i_if_flush) begin
                r_cancel <= 1'b1;
            end
        end
    end

    assign o_if_req_ready      = w_grant_if;
    assign o_d_req_ready       = w_grant_d;
    assign o_mem_read_address  = r_addr;
    assign o_mem_funct3        = r_funct3;
    assign o_mem_write_mem     = (r_state == StWrite);
    assign o_mem_write_address = r_addr;
    assign o_mem_write_data    = r_wdata;
    // A flush arriving during the response cycle itself must still suppress the pulse.
    assign o_if_rsp_valid      = (r_state == StResp) & r_owner_if & ~r_cancel & ~i_if_flush;
    assign o_d_rsp_valid       = (r_state == StResp) & ~r_owner_if;
    assign o_if_rsp_data       = r_rsp_data;
    assign o_d_rsp_data        = r_rsp_data;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: instance a uses MEM_LAT=1, instance b uses MEM_LAT=3.
module tb_mem_port_arbiter;
    logic        clk;
    logic        rst_n;
    logic        if_req_valid;
    logic [31:0] if_addr;
    logic        if_flush;
    logic        d_req_valid;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [2:0]  d_funct3;

    logic        a_if_req_ready, a_if_rsp_valid, a_d_req_ready, a_d_rsp_valid, a_mem_write_mem;
    logic [31:0] a_if_rsp_data, a_d_rsp_data, a_mem_read_address, a_mem_write_address;
    logic [31:0] a_mem_write_data, a_rdata;
    logic [2:0]  a_mem_funct3;
    logic        b_if_req_ready, b_if_rsp_valid, b_d_req_ready, b_d_rsp_valid, b_mem_write_mem;
    logic [31:0] b_if_rsp_data, b_d_rsp_data, b_mem_read_address, b_mem_write_address;
    logic [31:0] b_mem_write_data, b_rdata;
    logic [2:0]  b_mem_funct3;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          is_d;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  f3;
        logic [31:0] exp_data;
        logic [2:0]  exp_f3;
        int          exp_lat;
        int          exp_wr;
    } vec_t;

    vec_t vecs[7];

    // Read-only memory image: one fixed word, otherwise address XOR a constant.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h10) return 32'h0050_0093;
        return a ^ 32'h1357_9BDF;
    endfunction

    assign a_rdata = mem_word(a_mem_read_address);
    assign b_rdata = mem_word(b_mem_read_address);

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .MAX_STARVE(4)) u_dut_a (
        .clk                 (clk),
        .rst_n               (rst_n),
        .i_if_req_valid      (if_req_valid),
        .o_if_req_ready      (a_if_req_ready),
        .i_if_addr           (if_addr),
        .i_if_flush          (if_flush),
        .o_if_rsp_valid      (a_if_rsp_valid),
        .o_if_rsp_data       (a_if_rsp_data),
        .i_d_req_valid       (d_req_valid),
        .o_d_req_ready       (a_d_req_ready),
        .i_d_we              (d_we),
        .i_d_addr            (d_addr),
        .i_d_wdata           (d_wdata),
        .i_d_funct3          (d_funct3),
        .o_d_rsp_valid       (a_d_rsp_valid),
        .o_d_rsp_data        (a_d_rsp_data),
        .o_mem_read_address  (a_mem_read_address),
        .o_mem_funct3        (a_mem_funct3),
        .o_mem_write_mem     (a_mem_write_mem),
        .o_mem_write_address (a_mem_write_address),
        .o_mem_write_data    (a_mem_write_data),
        .i_mem_read_data     (a_rdata)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .MAX_STARVE(4)) u_dut_b (
        .clk                 (clk),
        .rst_n               (rst_n),
        .i_if_req_valid      (if_req_valid),
        .o_if_req_ready      (b_if_req_ready),
        .i_if_addr           (if_addr),
        .i_if_flush          (if_flush),
        .o_if_rsp_valid      (b_if_rsp_valid),
        .o_if_rsp_data       (b_if_rsp_data),
        .i_d_req_valid       (d_req_valid),
        .o_d_req_ready       (b_d_req_ready),
        .i_d_we              (d_we),
        .i_d_addr            (d_addr),
        .i_d_wdata           (d_wdata),
        .i_d_funct3          (d_funct3),
        .o_d_rsp_valid       (b_d_rsp_valid),
        .o_d_rsp_data        (b_d_rsp_data),
        .o_mem_read_address  (b_mem_read_address),
        .o_mem_funct3        (b_mem_funct3),
        .o_mem_write_mem     (b_mem_write_mem),
        .o_mem_write_address (b_mem_write_address),
        .o_mem_write_data    (b_mem_write_data),
        .i_mem_read_data     (b_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " if_req_ready"}, 32'(a_if_req_ready), 0);
        chk({tag, " d_req_ready"}, 32'(a_d_req_ready), 0);
        chk({tag, " if_rsp_valid"}, 32'(a_if_rsp_valid), 0);
        chk({tag, " d_rsp_valid"}, 32'(a_d_rsp_valid), 0);
        chk({tag, " rsp_data"}, a_if_rsp_data | a_d_rsp_data, 0);
        chk({tag, " read_address"}, a_mem_read_address, 0);
        chk({tag, " funct3"}, 32'(a_mem_funct3), 32'h2);
        chk({tag, " write_mem"}, 32'(a_mem_write_mem), 0);
        chk({tag, " write_address"}, a_mem_write_address, 0);
        chk({tag, " write_data"}, a_mem_write_data, 0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int          wait_c;
        int          rsp_k;
        int          pulses;
        int          wr_n;
        logic [31:0] rsp_d;
        bit          acc;
        @(posedge clk); #1;
        if (v.is_d) begin
            d_req_valid = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
            d_funct3 = v.f3;
        end else begin
            if_req_valid = 1'b1; if_addr = v.addr;
        end
        acc = 1'b0;
        wait_c = 0;
        while (!acc && wait_c < 10) begin
            @(negedge clk);
            acc = v.is_d ? a_d_req_ready : a_if_req_ready;
            @(posedge clk); #1;
            wait_c++;
        end
        d_req_valid = 1'b0;
        if_req_valid = 1'b0;
        chk($sformatf("vec%0d accepted", idx), 32'(acc), 1);
        rsp_k = -1; pulses = 0; wr_n = 0; rsp_d = '0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) begin
                chk($sformatf("vec%0d read_address", idx), a_mem_read_address, v.addr);
                chk($sformatf("vec%0d funct3", idx), 32'(a_mem_funct3), 32'(v.exp_f3));
            end
            if (a_mem_write_mem) begin
                wr_n++;
                chk($sformatf("vec%0d write_address", idx), a_mem_write_address, v.addr);
                chk($sformatf("vec%0d write_data", idx), a_mem_write_data, v.wdata);
            end
            if (v.is_d ? a_d_rsp_valid : a_if_rsp_valid) begin
                pulses++;
                if (rsp_k < 0) begin
                    rsp_k = k;
                    rsp_d = v.is_d ? a_d_rsp_data : a_if_rsp_data;
                end
            end
        end
        chk($sformatf("vec%0d rsp cycle", idx), 32'(rsp_k), 32'(v.exp_lat));
        chk($sformatf("vec%0d rsp data", idx), rsp_d, v.exp_data);
        chk($sformatf("vec%0d rsp pulses", idx), 32'(pulses), 1);
        chk($sformatf("vec%0d write cycles", idx), 32'(wr_n), 32'(v.exp_wr));
    endtask

    // Single request on instance b; if_flush is pulsed during post-accept cycle flush_k.
    task automatic b_txn(input bit is_d, input logic [31:0] addr, input int flush_k,
                         output bit acc, output int rsp_k, output logic [31:0] rsp_d,
                         output int pulses);
        int wait_c;
        @(posedge clk); #1;
        if (is_d) begin
            d_req_valid = 1'b1; d_we = 1'b0; d_addr = addr; d_funct3 = 3'b000;
        end else begin
            if_req_valid = 1'b1; if_addr = addr;
        end
        acc = 1'b0;
        wait_c = 0;
        while (!acc && wait_c < 10) begin
            @(negedge clk);
            acc = is_d ? b_d_req_ready : b_if_req_ready;
            @(posedge clk); #1;
            wait_c++;
        end
        d_req_valid = 1'b0;
        if_req_valid = 1'b0;
        rsp_k = -1; pulses = 0; rsp_d = '0;
        for (int k = 1; k <= 8; k++) begin
            if_flush = (k == flush_k);
            @(negedge clk);
            if (is_d ? b_d_rsp_valid : b_if_rsp_valid) begin
                pulses++;
                if (rsp_k < 0) begin
                    rsp_k = k;
                    rsp_d = is_d ? b_d_rsp_data : b_if_rsp_data;
                end
            end
            @(posedge clk); #1;
        end
        if_flush = 1'b0;
    endtask

    task automatic seq_both;
        int d_acc = -1, if_acc = -1, d_rsp = -1, if_rsp = -1;
        logic [31:0] if_d = '0;
        @(posedge clk); #1;
        if_req_valid = 1'b1; if_addr = 32'h4;
        d_req_valid = 1'b1; d_we = 1'b0; d_addr = 32'h100; d_funct3 = 3'b000;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (a_d_req_ready) d_acc = c;
            if (a_if_req_ready) if_acc = c;
            if (a_d_rsp_valid && d_rsp < 0) d_rsp = c;
            if (a_if_rsp_valid && if_rsp < 0) begin
                if_rsp = c;
                if_d = a_if_rsp_data;
            end
            @(posedge clk); #1;
            if (d_acc == c) d_req_valid = 1'b0;
            if (if_acc == c) if_req_valid = 1'b0;
        end
        d_req_valid = 1'b0;
        if_req_valid = 1'b0;
        chk("both d accept cycle", 32'(d_acc), 0);
        chk("both d rsp cycle", 32'(d_rsp), 2);
        chk("both if accept cycle", 32'(if_acc), 3);
        chk("both if rsp cycle", 32'(if_rsp), 5);
        chk("both if rsp data", if_d, 32'h1357_9BDB);
    endtask

    task automatic seq_starve;
        logic [7:0] got [6];
        logic [7:0] exp [6];
        int n = 0;
        bit g_if, g_d;
        exp = '{"D", "D", "D", "D", "I", "D"};
        got = '{default: 8'h0};
        @(posedge clk); #1;
        if_req_valid = 1'b1; if_addr = 32'h8;
        d_req_valid = 1'b1; d_we = 1'b0; d_addr = 32'h100; d_funct3 = 3'b000;
        for (int c = 0; c < 60 && n < 6; c++) begin
            @(negedge clk);
            g_if = a_if_req_ready;
            g_d  = a_d_req_ready;
            if (g_d) begin
                got[n] = "D"; n++;
            end else if (g_if) begin
                got[n] = "I"; n++;
            end
            @(posedge clk); #1;
            if (g_if) if_req_valid = 1'b0;
        end
        d_req_valid = 1'b0;
        if_req_valid = 1'b0;
        chk("starve grant count", 32'(n), 6);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("starve grant %0d", i), 32'(got[i]), 32'(exp[i]));
        end
    endtask

    task automatic seq_flush;
        bit          acc;
        int          rsp_k, pulses;
        logic [31:0] rsp_d;
        b_txn(1'b0, 32'h8, 2, acc, rsp_k, rsp_d, pulses);
        chk("flush wait accepted", 32'(acc), 1);
        chk("flush wait if pulses", 32'(pulses), 0);
        b_txn(1'b0, 32'hC, 0, acc, rsp_k, rsp_d, pulses);
        chk("after flush rsp cycle", 32'(rsp_k), 4);
        chk("after flush rsp data", rsp_d, 32'h1357_9BD3);
        chk("after flush pulses", 32'(pulses), 1);
        b_txn(1'b0, 32'h4, 4, acc, rsp_k, rsp_d, pulses);
        chk("flush in resp pulses", 32'(pulses), 0);
        b_txn(1'b1, 32'h100, 2, acc, rsp_k, rsp_d, pulses);
        chk("flush d rsp cycle", 32'(rsp_k), 4);
        chk("flush d rsp data", rsp_d, 32'h1357_9ADF);
    endtask

    task automatic seq_async_reset;
        int stray = 0;
        @(posedge clk); #1;
        d_req_valid = 1'b1; d_we = 1'b1; d_addr = 32'h300; d_wdata = 32'h1234_5678;
        d_funct3 = 3'b010;
        @(negedge clk);
        chk("rst store ready", 32'(a_d_req_ready), 1);
        @(posedge clk); #1;
        d_req_valid = 1'b0;
        chk("rst pre write_mem", 32'(a_mem_write_mem), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("async rst");
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (a_d_rsp_valid || a_if_rsp_valid || a_mem_write_mem) stray++;
        end
        chk("post reset stray activity", 32'(stray), 0);
    endtask

    initial begin
        vecs[0] = '{0, 0, 32'h10,  32'h0,         3'b000, 32'h0050_0093, 3'b010, 2, 0};
        vecs[1] = '{0, 0, 32'h4,   32'h0,         3'b000, 32'h1357_9BDB, 3'b010, 2, 0};
        vecs[2] = '{1, 0, 32'h100, 32'h0,         3'b000, 32'h1357_9ADF, 3'b000, 2, 0};
        vecs[3] = '{1, 1, 32'h200, 32'hDEAD_BEEF, 3'b010, 32'h0,         3'b010, 2, 1};
        vecs[4] = '{1, 0, 32'h20,  32'h0,         3'b100, 32'h1357_9BFF, 3'b100, 2, 0};
        vecs[5] = '{1, 1, 32'h44,  32'h0000_00AB, 3'b000, 32'h0,         3'b000, 2, 1};
        vecs[6] = '{0, 0, 32'h10,  32'h0,         3'b000, 32'h0050_0093, 3'b010, 2, 0};

        rst_n = 1'b0;
        if_req_valid = 1'b0; if_addr = '0; if_flush = 1'b0;
        d_req_valid = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_funct3 = '0;
        #12;
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (3) @(posedge clk);

        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i], i);
        end
        repeat (8) @(posedge clk);
        seq_both();
        repeat (10) @(posedge clk);
        seq_starve();
        repeat (10) @(posedge clk);
        seq_flush();
        repeat (10) @(posedge clk);
        seq_async_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
